nuniv_shift_reg: RTL

//  Parametrised N-bit universal shift register, successor to the fixed serial-in left/right shifter.

---
 rtl/nuniv_shift_reg.sv | 117 +++++++++++
 1 files changed

// File: rtl/nuniv_shift_reg.sv
// Parametrised N-bit universal shift register with manual modes and a
// self-timed burst serialiser (busy/done handshake, pausable via en).
module nuniv_shift_reg #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic         sin_lsb,
    input  logic         sin_msb,
    input  logic [N-1:0] pdata,
    input  logic         start,
    input  logic         bdir,
    output logic [N-1:0] q,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          act_dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state: start wins over mode in IDLE; done is a self-clearing pulse.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        q_d     = pdata;
                        cnt_d   = '0;
                        dir_d   = bdir;
                        busy_d  = 1'b1;
                        state_d = BURST;
                    end else begin
                        case (mode)
                            MODE_HOLD: q_d = q_q;
                            MODE_SHL:  q_d = {q_q[N-2:0], sin_lsb};
                            MODE_SHR:  q_d = {sin_msb, q_q[N-1:1]};
                            MODE_ROL:  q_d = {q_q[N-2:0], q_q[N-1]};
                            MODE_ROR:  q_d = {q_q[0], q_q[N-1:1]};
                            MODE_LOAD: q_d = pdata;
                            MODE_ASR:  q_d = {q_q[N-1], q_q[N-1:1]};
                            MODE_CLR:  q_d = '0;
                            default:   q_d = q_q;
                        endcase
                    end
                end
                BURST: begin
                    q_d = dir_q ? {sin_msb, q_q[N-1:1]} : {q_q[N-2:0], sin_lsb};
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Latched direction steers sout during a burst; the live input otherwise.
    assign act_dir = (state_q == BURST) ? dir_q : bdir;
    assign sout    = act_dir ? q_q[0] : q_q[N-1];
    assign q       = q_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
